// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory port arbiter between core load/store path and DMA bursts
module dmem_arbiter #(
    parameter int         MAX_BURST = 16,
    parameter logic [2:0] LW_SEL    = 3'b010,
    parameter logic [1:0] SW_SEL    = 2'b10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_wr,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [2:0]  core_load_sel,
    input  logic [1:0]  core_store_sel,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [31:0] dma_addr,
    input  logic [4:0]  dma_len,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic        dma_done,
    output logic        dma_busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr_en,
    output logic [2:0]  mem_load_sel,
    output logic [1:0]  mem_store_sel,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BURST, HOLDOFF} state_t;

    state_t      state;
    logic [31:0] base;
    logic        wr;
    logic [4:0]  len;
    logic [4:0]  cnt;
    logic [4:0]  eff_len;
    logic        in_burst;

    always_comb begin
        eff_len = dma_len;
        if (dma_len == 5'd0)
            eff_len = 5'd1;
        else if (int'(dma_len) > MAX_BURST)
            eff_len = 5'(MAX_BURST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            base       <= '0;
            wr         <= 1'b0;
            len        <= '0;
            cnt        <= '0;
            dma_rdata  <= '0;
            dma_rvalid <= 1'b0;
            dma_done   <= 1'b0;
        end else begin
            dma_rvalid <= 1'b0;
            dma_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (dma_req) begin
                        base  <= dma_addr & ~32'h3;
                        wr    <= dma_wr;
                        len   <= eff_len;
                        cnt   <= '0;
                        state <= BURST;
                    end
                end
                BURST: begin
                    cnt <= cnt + 5'd1;
                    if (!wr) begin
                        dma_rdata  <= mem_rdata;
                        dma_rvalid <= 1'b1;
                    end
                    if (cnt == len - 5'd1) begin
                        state    <= HOLDOFF;
                        dma_done <= 1'b1;
                    end
                end
                HOLDOFF: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outside a burst the core owns the port with no added latency.
    assign in_burst      = (state == BURST);
    assign mem_addr      = in_burst ? base + {25'd0, cnt, 2'b00} : core_addr;
    assign mem_wdata     = in_burst ? dma_wdata : core_wdata;
    assign mem_wr_en     = in_burst ? wr : (core_req & core_wr);
    assign mem_load_sel  = in_burst ? LW_SEL : core_load_sel;
    assign mem_store_sel = in_burst ? SW_SEL : core_store_sel;
    assign core_stall    = in_burst & core_req;
    assign core_rdata    = mem_rdata;
    assign dma_gnt       = in_burst;
    assign dma_busy      = (state != IDLE);

endmodule
